// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the sync_fifo_flex slice.
// Every width derived from DEPTH is computed here, so the top, the
// storage and the bus interface always agree.
//   addr_w(depth) : RAM address width, log2(depth)
//   ptr_w(depth)  : read/write pointer width, log2(depth)+1.
//                   The extra MSB tells full apart from empty.
//   cnt_w(depth)  : fill-level width. It must hold 0..depth, so it
//                   equals the pointer width.
package sync_fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle of sync_fifo_flex.
//   master : the FIFO user. It drives flush_i, wen_i, wdata_i and ren_i,
//            and observes the data and status outputs.
//   slave  : the FIFO itself.
// DEPTH and DWIDTH must match the parameters of the attached FIFO.
interface sync_fifo_flex_if #(
  parameter int DEPTH  = 32,
  parameter int DWIDTH = 8
);
  import sync_fifo_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic              flush_i;
  logic              wen_i;
  logic [DWIDTH-1:0] wdata_i;
  logic              ren_i;
  logic [DWIDTH-1:0] rdata_o;
  logic              rvalid_o;
  logic              full_o;
  logic              empty_o;
  logic              afull_o;
  logic              aempty_o;
  logic [CW-1:0]     count_o;
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output flush_i, wen_i, wdata_i, ren_i,
    input  rdata_o, rvalid_o, full_o, empty_o, afull_o, aempty_o,
           count_o, ovf_o, udf_o
  );

  modport slave (
    input  flush_i, wen_i, wdata_i, ren_i,
    output rdata_o, rvalid_o, full_o, empty_o, afull_o, aempty_o,
           count_o, ovf_o, udf_o
  );

endinterface

// File: rtl/fifo_ram.sv
// Storage array of sync_fifo_flex.
// It has one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents are undefined until written.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module fifo_ram import sync_fifo_pkg::*; #(
  parameter int DEPTH  = 32,
  parameter int DWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [DWIDTH-1:0]         rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with configurable thresholds and read mode.
//
// Ports:
//   clk : clock. All state updates on posedge.
//   rst : synchronous active-high reset. It overrides flush and all
//         accesses.
//   bus : sync_fifo_flex_if slave modport.
//     flush_i  : clears pointers and flags. No access happens that cycle.
//     wen_i    : write request; wdata_i is the write data.
//     ren_i    : read request.
//     rdata_o  : read data; rvalid_o qualifies it.
//     full_o, empty_o, afull_o, aempty_o : level flags.
//     count_o  : fill level, 0..DEPTH.
//     ovf_o    : sticky flag for a rejected write.
//     udf_o    : sticky flag for a rejected read.
//
// Read modes:
//   FWFT=1 : the head word is presented combinationally, and
//            rvalid_o = !empty_o.
//   FWFT=0 : the head word is registered on an accepted read, and
//            rvalid_o pulses for one cycle.
module sync_fifo_flex import sync_fifo_pkg::*; #(
  parameter int DEPTH     = 32,
  parameter int DWIDTH    = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 1
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flex_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     count;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf;
  logic              udf;
  logic [DWIDTH-1:0] ram_rdata;

  // The pointers run modulo 2*DEPTH, so their difference is the exact
  // fill level, including the full case.
  assign count = wptr - rptr;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A flush takes precedence, so no access is accepted in a flush cycle.
  // When the FIFO is full, a write is still accepted if a read frees a
  // slot in the same cycle.
  assign rd_acc = bus.ren_i & ~empty & ~bus.flush_i;
  assign wr_acc = bus.wen_i & (~full | rd_acc) & ~bus.flush_i;

  fifo_ram #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.wdata_i),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (bus.flush_i) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (bus.wen_i && !wr_acc) ovf <= 1'b1;
      if (bus.ren_i && !rd_acc) udf <= 1'b1;
    end
  end

  assign bus.count_o  = count;
  assign bus.full_o   = full;
  assign bus.empty_o  = empty;
  assign bus.afull_o  = (count >= AFULL_C);
  assign bus.aempty_o = (count <= AEMPTY_C);
  assign bus.ovf_o    = ovf;
  assign bus.udf_o    = udf;

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata_o  = ram_rdata;
    assign bus.rvalid_o = ~empty;
  end else begin : g_reg
    logic [DWIDTH-1:0] rdata_p1;
    logic              vld_p1;

    // registered read stage
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else if (bus.flush_i) begin
        vld_p1   <= 1'b0;
      end else begin
        vld_p1   <= rd_acc;
        if (rd_acc) rdata_p1 <= ram_rdata;
      end
    end

    assign bus.rdata_o  = rdata_p1;
    assign bus.rvalid_o = vld_p1;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex with DEPTH=4, AFULL_TH=3 and
// AEMPTY_TH=1.
//   u_a : FWFT=1 instance
//   u_b : FWFT=0 instance
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DEPTH(4), .DWIDTH(8)) if_a ();
  sync_fifo_flex_if #(.DEPTH(4), .DWIDTH(8)) if_b ();

  sync_fifo_flex #(
    .DEPTH(4), .DWIDTH(8), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sync_fifo_flex #(
    .DEPTH(4), .DWIDTH(8), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then examined 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.wen_i = 1'b0; if_a.ren_i = 1'b0; if_a.flush_i = 1'b0;
  endtask

  task automatic idle_b();
    if_b.wen_i = 1'b0; if_b.ren_i = 1'b0; if_b.flush_i = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_count"},  32'(if_a.count_o),  0);
    chk({tag, "_empty"},  32'(if_a.empty_o),  1);
    chk({tag, "_aempty"}, 32'(if_a.aempty_o), 1);
    chk({tag, "_full"},   32'(if_a.full_o),   0);
    chk({tag, "_afull"},  32'(if_a.afull_o),  0);
    chk({tag, "_ovf"},    32'(if_a.ovf_o),    0);
    chk({tag, "_udf"},    32'(if_a.udf_o),    0);
    chk({tag, "_rvalid"}, 32'(if_a.rvalid_o), 0);
  endtask

  logic [7:0] wvals [4];
  logic [7:0] exp_q [4];

  initial begin
    wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;
    idle_a(); idle_b();
    if_a.wdata_i = 8'h00; if_b.wdata_i = 8'h00;

    // ---- reset ----
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_reset_a("rst_a");
    chk("rst_b_rdata",  32'(if_b.rdata_o),  0);
    chk("rst_b_rvalid", 32'(if_b.rvalid_o), 0);

    // ---- underflow on empty read ----
    if_a.ren_i = 1'b1; tick(); idle_a();
    chk("udf_set",   32'(if_a.udf_o),   1);
    chk("udf_count", 32'(if_a.count_o), 0);
    chk("udf_empty", 32'(if_a.empty_o), 1);
    if_a.flush_i = 1'b1; tick(); idle_a();
    chk("udf_flushed", 32'(if_a.udf_o), 0);

    // ---- fill to full, overflow, drain in order ----
    for (int i = 0; i < 4; i++) begin
      if_a.wen_i = 1'b1; if_a.wdata_i = wvals[i]; tick();
      chk($sformatf("fill_count%0d", i), 32'(if_a.count_o), 32'(i + 1));
      chk($sformatf("fill_afull%0d", i), 32'(if_a.afull_o), (i >= 2) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), 32'(if_a.full_o), (i == 3) ? 1 : 0);
      chk($sformatf("fill_aempty%0d", i), 32'(if_a.aempty_o), (i == 0) ? 1 : 0);
    end
    if_a.wdata_i = 8'h55; tick(); idle_a();
    chk("ovf_set",   32'(if_a.ovf_o),   1);
    chk("ovf_count", 32'(if_a.count_o), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_rdata%0d", i), 32'(if_a.rdata_o), 32'(wvals[i]));
      chk($sformatf("drain_rvalid%0d", i), 32'(if_a.rvalid_o), 1);
      if_a.ren_i = 1'b1; tick(); idle_a();
    end
    chk("drain_empty", 32'(if_a.empty_o), 1);
    chk("drain_ovf_sticky", 32'(if_a.ovf_o), 1);

    // ---- flush with 3 entries and ovf set; a same-cycle write is ignored ----
    for (int i = 0; i < 3; i++) begin
      if_a.wen_i = 1'b1; if_a.wdata_i = 8'hA0 + 8'(i); tick();
    end
    idle_a();
    chk("pre_flush_count", 32'(if_a.count_o), 3);
    if_a.flush_i = 1'b1; if_a.wen_i = 1'b1; if_a.wdata_i = 8'hEE; tick(); idle_a();
    chk("flush_count", 32'(if_a.count_o), 0);
    chk("flush_empty", 32'(if_a.empty_o), 1);
    chk("flush_ovf",   32'(if_a.ovf_o),   0);

    // ---- simultaneous read and write when full ----
    for (int i = 0; i < 4; i++) begin
      if_a.wen_i = 1'b1; if_a.wdata_i = wvals[i]; tick();
    end
    if_a.wen_i = 1'b1; if_a.ren_i = 1'b1; if_a.wdata_i = 8'h66; tick(); idle_a();
    chk("rw_full_count", 32'(if_a.count_o), 4);
    chk("rw_full_ovf",   32'(if_a.ovf_o),   0);
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rw_full_rd%0d", i), 32'(if_a.rdata_o), 32'(exp_q[i]));
      if_a.ren_i = 1'b1; tick(); idle_a();
    end
    chk("rw_full_udf", 32'(if_a.udf_o), 0);

    // ---- simultaneous read and write when empty (FWFT) ----
    if_a.wen_i = 1'b1; if_a.ren_i = 1'b1; if_a.wdata_i = 8'h77; tick(); idle_a();
    chk("rw_empty_count",  32'(if_a.count_o),  1);
    chk("rw_empty_udf",    32'(if_a.udf_o),    1);
    chk("rw_empty_rdata",  32'(if_a.rdata_o),  8'h77);
    chk("rw_empty_rvalid", 32'(if_a.rvalid_o), 1);

    // ---- reset mid-stream ----
    if_a.wen_i = 1'b1; if_a.wdata_i = 8'h88; tick(); idle_a();
    if_a.wen_i = 1'b1; if_a.wdata_i = 8'h99; tick(); idle_a();
    chk("pre_rst_count", 32'(if_a.count_o), 3);
    rst = 1'b1; if_a.wen_i = 1'b1; tick(); rst = 1'b0; idle_a();
    chk_reset_a("midrst_a");

    // ---- registered-read instance ----
    if_b.wen_i = 1'b1; if_b.wdata_i = 8'hA0; tick();
    if_b.wdata_i = 8'hA1; tick(); idle_b();
    chk("reg_no_valid", 32'(if_b.rvalid_o), 0);
    chk("reg_count2",   32'(if_b.count_o),  2);
    if_b.ren_i = 1'b1; tick(); idle_b();
    chk("reg_rvalid", 32'(if_b.rvalid_o), 1);
    chk("reg_rdata",  32'(if_b.rdata_o),  8'hA0);
    tick();
    chk("reg_rvalid_drop", 32'(if_b.rvalid_o), 0);
    chk("reg_rdata_hold",  32'(if_b.rdata_o),  8'hA0);
    for (int i = 0; i < 10; i++) begin
      if_b.wen_i = 1'b1; if_b.ren_i = 1'b1; if_b.wdata_i = 8'hB0 + 8'(i); tick();
      chk($sformatf("wrap_rvalid%0d", i), 32'(if_b.rvalid_o), 1);
      chk($sformatf("wrap_rdata%0d", i), 32'(if_b.rdata_o),
          (i == 0) ? 32'h A1 : 32'(8'hB0 + 8'(i - 1)));
    end
    idle_b();
    chk("wrap_count", 32'(if_b.count_o), 1);
    tick();
    chk("wrap_rvalid_end", 32'(if_b.rvalid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of entries; power of two, >= 2.
REQ-002 SHALL have parameter DWIDTH, default 8: data width in bits, >= 1.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: almost-full threshold in entries, 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_TH, default 2: almost-empty threshold in entries, 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through read; 0 = registered read.
REQ-006 SHALL have a single clock with synchronous active-high reset: clk  input  1  clock, all state on posedge.
REQ-007 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port: flush_i  input  1  synchronous clear of contents and flags.
REQ-009 SHALL have port: wen_i  input  1  write request.
REQ-010 SHALL have port: wdata_i  input  DWIDTH  write data.
REQ-011 SHALL have port: ren_i  input  1  read request.
REQ-012 SHALL have port: rdata_o  output  DWIDTH  read data.
REQ-013 SHALL have port: rvalid_o  output  1  rdata_o holds valid data.
REQ-014 SHALL have port: full_o, empty_o, afull_o, aempty_o  output  1 each  level flags.
REQ-015 SHALL have port: count_o  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
REQ-016 SHALL have port: ovf_o, udf_o  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 SHALL accept a read: rd_acc = ren_i & !empty_o.
REQ-018 SHALL accept a write: wr_acc = wen_i & (!full_o | rd_acc), so a simultaneous read and write when full both succeed.
REQ-019 SHALL, on simultaneous read and write when empty, accept only the write; the read is rejected and flagged.
REQ-020 SHALL use (log2 DEPTH)+1-bit read/write pointers wrapping modulo 2*DEPTH; count = wptr - rptr; full when count == DEPTH; empty when count == 0.
REQ-021 SHALL drive afull_o = (count >= AFULL_TH) and aempty_o = (count <= AEMPTY_TH), both combinational from registered count.
REQ-022 SHALL update count_o on the clock edge after an accepted access: +1 write only, -1 read only, unchanged for both or neither.
REQ-023 SHALL, with FWFT=1, drive rdata_o = mem[rptr] combinationally and rvalid_o = !empty_o; a written word is visible the cycle after the write.
REQ-024 SHALL, with FWFT=0, register mem[rptr] into rdata_o on the edge where rd_acc=1, assert rvalid_o for exactly the following cycle, and hold rdata_o otherwise.
REQ-025 SHALL set ovf_o on the edge after wen_i=1 with wr_acc=0; memory and pointers unchanged; sticky.
REQ-026 SHALL set udf_o on the edge after ren_i=1 with rd_acc=0; pointers unchanged; sticky.
REQ-027 SHALL, on flush_i=1, zero both pointers, ovf_o, udf_o and rvalid_o on the next edge; flush overrides same-cycle wen_i/ren_i (no access, no error flag).
REQ-028 SHALL leave memory contents uninitialised; there is no reset on the storage array.

Reset
REQ-029 SHALL, on rst=1 at posedge clk, set pointers=0, count_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, ovf_o=0, udf_o=0, rvalid_o=0, rdata_o=0 (FWFT=0 only).
REQ-030 SHALL give rst priority over flush_i and all accesses; asserting rst mid-stream discards all contents.

Structure
REQ-031 SHALL place pointer-width and count-width constants derived from DEPTH in shared package sync_fifo_pkg.
REQ-032 SHALL implement storage in sub-module fifo_ram (1 write port, 1 async read port, no reset), instantiated once.
REQ-033 SHALL keep control (pointers, flags, read register) in sync_fifo_flex itself.

Verification (DEPTH=4, DWIDTH=8, AFULL_TH=3, AEMPTY_TH=1)
REQ-034 SHALL cover: write 0x11,0x22,0x33,0x44 -> count_o 1..4, afull_o at count 3, full_o at count 4; 5th write 0x55 -> ovf_o=1, count_o stays 4, reads return 0x11..0x44 in order.
REQ-035 SHALL cover: read when empty after reset -> udf_o=1, count_o=0, empty_o stays 1.
REQ-036 SHALL cover: when full, wen_i=ren_i=1 with 0x66 -> count_o stays 4, no ovf_o, 0x66 read last after 0x22..0x44.
REQ-037 SHALL cover: when empty, FWFT=1, wen_i=ren_i=1 with 0x77 -> count_o=1, udf_o=1, rdata_o=0x77 with rvalid_o=1 next cycle.
REQ-038 SHALL cover: FWFT=0, two entries, ren_i pulse -> rvalid_o high exactly one cycle later with first word; 10 write/read cycles wrap pointers with data intact.
REQ-039 SHALL cover: flush_i with 3 entries and ovf_o=1 -> next cycle count_o=0, empty_o=1, ovf_o=0; rst mid-stream -> all REQ-029 values.
